// File: rtl/intr_timer_ctrl.sv
// Interrupt/timer controller: prescaled machine timer, external interrupt synchronisers,
// pending/enable registers and a fixed-priority request to the CSR unit.
// Build option INTR_EDGE_TRIGGER_EN selects edge-latched ext pending bits (default: level).
module intr_timer_ctrl #(
    parameter int NUM_EXT = 4,
    parameter int TIMER_W = 32,
    localparam int ID_W   = $clog2(NUM_EXT + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_EXT-1:0] ext_irq,
    input  logic [2:0]         addr,
    input  logic [31:0]        wdata,
    input  logic               wr_en,
    input  logic               rd_en,
    output logic [31:0]        rdata,
    output logic               irq_req,
    output logic [ID_W-1:0]    irq_id,
    input  logic               irq_ack,
    output logic               timer_irq
);

    logic [TIMER_W-1:0] mtime_q, mtime_d;
    logic [TIMER_W-1:0] mtimecmp_q, mtimecmp_d;
    logic [7:0]         presc_q, presc_d;
    logic [7:0]         pcnt_q, pcnt_d;
    logic [NUM_EXT:0]   en_q, en_d;
    logic [NUM_EXT-1:0] ext_pend_q, ext_pend_d;
    logic [NUM_EXT-1:0] sync1_q, sync2_q, sync3_q;
    logic               timer_irq_q;
    logic [31:0]        rdata_q, rdata_d;

    logic               wr_mtime, wr_cmp, wr_presc, wr_en_reg, wr_pend;
    logic               tick;
    logic [NUM_EXT:0]   act;
    logic [NUM_EXT-1:0] ext_set, ext_keep, ext_clr;

    assign wr_mtime  = wr_en && (addr == 3'd0);
    assign wr_cmp    = wr_en && (addr == 3'd1);
    assign wr_presc  = wr_en && (addr == 3'd2);
    assign wr_en_reg = wr_en && (addr == 3'd3);
    assign wr_pend   = wr_en && (addr == 3'd4);

    // Timer datapath: a direct MTIME write overrides the increment in the same cycle.
    assign tick = (pcnt_q == presc_q);

    always_comb begin
        pcnt_d     = (wr_presc || tick) ? 8'd0 : pcnt_q + 8'd1;
        mtime_d    = wr_mtime ? wdata[TIMER_W-1:0] : (tick ? mtime_q + 1'b1 : mtime_q);
        mtimecmp_d = wr_cmp ? wdata[TIMER_W-1:0] : mtimecmp_q;
        presc_d    = wr_presc ? wdata[7:0] : presc_q;
        en_d       = wr_en_reg ? wdata[NUM_EXT:0] : en_q;
    end

    assign act     = {ext_pend_q, timer_irq_q} & en_q;
    assign irq_req = |act;

    always_comb begin
        irq_id = '0;
        for (int i = NUM_EXT; i >= 0; i--)
            if (act[i]) irq_id = ID_W'(i);
    end

    always_comb begin
        ext_clr = '0;
        for (int k = 0; k < NUM_EXT; k++)
            ext_clr[k] = (irq_req && irq_ack && (irq_id == ID_W'(k + 1))) ||
                         (wr_pend && wdata[k+1]);
    end

    // Level build holds nothing across cycles, so ack/W1C can never stick there.
`ifdef INTR_EDGE_TRIGGER_EN
    assign ext_set  = sync2_q & ~sync3_q;
    assign ext_keep = '1;
`else
    assign ext_set  = sync2_q;
    assign ext_keep = '0;
`endif
    assign ext_pend_d = ext_set | (ext_pend_q & ext_keep & ~ext_clr);

    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            case (addr)
                3'd0:    rdata_d = 32'(mtime_q);
                3'd1:    rdata_d = 32'(mtimecmp_q);
                3'd2:    rdata_d = 32'(presc_q);
                3'd3:    rdata_d = 32'(en_q);
                3'd4:    rdata_d = 32'({ext_pend_q, timer_irq_q});
                default: rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtime_q     <= '0;
            mtimecmp_q  <= '1;
            presc_q     <= '0;
            pcnt_q      <= '0;
            en_q        <= '0;
            ext_pend_q  <= '0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            sync3_q     <= '0;
            timer_irq_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            presc_q     <= presc_d;
            pcnt_q      <= pcnt_d;
            en_q        <= en_d;
            ext_pend_q  <= ext_pend_d;
            sync1_q     <= ext_irq;
            sync2_q     <= sync1_q;
            sync3_q     <= sync2_q;
            timer_irq_q <= (mtime_q >= mtimecmp_q);
            rdata_q     <= rdata_d;
        end
    end

    assign timer_irq = timer_irq_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_intr_timer_ctrl.sv
// Directed bench for intr_timer_ctrl: register table plus timer, reset, wrap and ext-irq sequences.
// Ext-irq sequences follow the INTR_EDGE_TRIGGER_EN build option.
module tb_intr_timer_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ext_irq;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic        wr_en, rd_en, irq_ack;
    logic [31:0] rdata, rdata8;
    logic        irq_req, irq_req8, timer_irq, timer_irq8;
    logic [2:0]  irq_id, irq_id8;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    intr_timer_ctrl #(.NUM_EXT(4), .TIMER_W(32)) dut (
        .clk(clk), .rst(rst), .ext_irq(ext_irq), .addr(addr), .wdata(wdata),
        .wr_en(wr_en), .rd_en(rd_en), .rdata(rdata), .irq_req(irq_req),
        .irq_id(irq_id), .irq_ack(irq_ack), .timer_irq(timer_irq)
    );

    intr_timer_ctrl #(.NUM_EXT(4), .TIMER_W(8)) dut8 (
        .clk(clk), .rst(rst), .ext_irq(ext_irq), .addr(addr), .wdata(wdata),
        .wr_en(wr_en), .rd_en(rd_en), .rdata(rdata8), .irq_req(irq_req8),
        .irq_id(irq_id8), .irq_ack(irq_ack), .timer_irq(timer_irq8)
    );

    typedef struct {
        logic        wr;
        logic [2:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // All tasks start and end just after a falling edge; each bus access spans one rising edge.
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a);
        addr = a; rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        rst = 1'b0; ext_irq = '0; addr = '0; wdata = '0;
        wr_en = 1'b0; rd_en = 1'b0; irq_ack = 1'b0;

        #3;
        chk("por_irq_req", 32'(irq_req), 0);
        chk("por_timer_irq", 32'(timer_irq), 0);
        chk("por_rdata", rdata, 0);
        @(negedge clk);
        rst = 1'b1;

        // Reset with a timer request outstanding and MTIME=0x55
        wr(3'd1, 32'd0);
        wr(3'd3, 32'h1);
        wr(3'd0, 32'h55);
        chk("pre_rst_irq_req", 32'(irq_req), 1);
        rd(3'd0);
        chk("pre_rst_mtime", rdata, 32'h55);
        #2 rst = 1'b0;
        #1;
        chk("rst_irq_req", 32'(irq_req), 0);
        chk("rst_irq_id", 32'(irq_id), 0);
        chk("rst_timer_irq", 32'(timer_irq), 0);
        chk("rst_rdata", rdata, 0);
        @(negedge clk);
        rst = 1'b1;
        rd(3'd0);
        chk("rst_mtime", rdata, 0);
        rd(3'd1);
        chk("rst_mtimecmp", rdata, 32'hFFFF_FFFF);

        // Register map table
        vecs.push_back('{1'b1, 3'd2, 32'h0000_01FF, 32'h0});
        vecs.push_back('{1'b0, 3'd2, 32'h0,         32'h0000_00FF});
        vecs.push_back('{1'b0, 3'd3, 32'h0,         32'h0});
        vecs.push_back('{1'b1, 3'd3, 32'hFFFF_FFFF, 32'h0});
        vecs.push_back('{1'b0, 3'd3, 32'h0,         32'h0000_001F});
        vecs.push_back('{1'b1, 3'd5, 32'h0000_1234, 32'h0});
        vecs.push_back('{1'b0, 3'd5, 32'h0,         32'h0});
        vecs.push_back('{1'b0, 3'd6, 32'h0,         32'h0});
        vecs.push_back('{1'b0, 3'd7, 32'h0,         32'h0});
        vecs.push_back('{1'b1, 3'd1, 32'hDEAD_BEEF, 32'h0});
        vecs.push_back('{1'b0, 3'd1, 32'h0,         32'hDEAD_BEEF});
        vecs.push_back('{1'b0, 3'd4, 32'h0,         32'h0});
        vecs.push_back('{1'b1, 3'd4, 32'h0000_00FF, 32'h0});
        vecs.push_back('{1'b0, 3'd4, 32'h0,         32'h0});
        vecs.push_back('{1'b1, 3'd0, 32'h0000_1000, 32'h0});
        vecs.push_back('{1'b0, 3'd0, 32'h0,         32'h0000_1000});
        foreach (vecs[i]) begin
            if (vecs[i].wr) wr(vecs[i].a, vecs[i].d);
            else begin
                rd(vecs[i].a);
                chk($sformatf("regmap_%0d", i), rdata, vecs[i].exp);
            end
        end
        idle(3);
        chk("rdata_hold", rdata, 32'h0000_1000);
        chk("regmap_irq_req", 32'(irq_req), 0);
        wr(3'd3, 32'h0);
        wr(3'd2, 32'h0);
        wr(3'd1, 32'hFFFF_FFFF);

        // Timer: PRESCALE=3 written at edge P, MTIME=0 at P+1 -> MTIME=k after P+4k
        wr(3'd1, 32'd10);
        wr(3'd3, 32'h1);
        wr(3'd2, 32'd3);
        wr(3'd0, 32'd0);
        idle(20);
        rd(3'd0);
        chk("tmr_mtime_5", rdata, 32'd5);
        idle(2);
        rd(3'd0);
        chk("tmr_mtime_6", rdata, 32'd6);
        idle(15);
        chk("tmr_irq_before", 32'(timer_irq), 0);
        chk("tmr_req_before", 32'(irq_req), 0);
        idle(1);
        chk("tmr_irq_rise", 32'(timer_irq), 1);
        chk("tmr_req_rise", 32'(irq_req), 1);
        chk("tmr_id", 32'(irq_id), 0);
        wr(3'd1, 32'd100);
        chk("tmr_irq_hold", 32'(timer_irq), 1);
        idle(1);
        chk("tmr_irq_drop", 32'(timer_irq), 0);
        chk("tmr_req_drop", 32'(irq_req), 0);
        wr(3'd3, 32'h0);
        wr(3'd2, 32'h0);
        wr(3'd1, 32'hFFFF_FFFF);

        // Wrap on the 8-bit instance, write-over-increment on both
        wr(3'd0, 32'hFF);
        rd(3'd0);
        chk("wrap8_ff", rdata8, 32'hFF);
        chk("wrap32_ff", rdata, 32'hFF);
        rd(3'd0);
        chk("wrap8_00", rdata8, 32'h00);
        chk("wrap32_100", rdata, 32'h100);
        wr(3'd0, 32'h42);
        rd(3'd0);
        chk("wr_prio8", rdata8, 32'h42);
        chk("wr_prio32", rdata, 32'h42);

`ifdef INTR_EDGE_TRIGGER_EN
        // Disabled pending bit, ack with no request, then enable
        ext_irq = 4'b0001;
        idle(1);
        ext_irq = 4'b0000;
        idle(2);
        chk("edge_dis_req", 32'(irq_req), 0);
        rd(3'd4);
        chk("edge_dis_pend", rdata, 32'h2);
        irq_ack = 1'b1;
        idle(1);
        irq_ack = 1'b0;
        rd(3'd4);
        chk("edge_ack_noreq", rdata, 32'h2);
        wr(3'd3, 32'h2);
        chk("edge_en_req", 32'(irq_req), 1);
        chk("edge_en_id", 32'(irq_id), 1);

        // New edge arrives on the same edge as irq_ack for id 1 -> set wins
        ext_irq = 4'b0001;
        idle(1);
        ext_irq = 4'b0000;
        idle(1);
        irq_ack = 1'b1;
        idle(1);
        irq_ack = 1'b0;
        chk("coll_req", 32'(irq_req), 1);
        rd(3'd4);
        chk("coll_pend", rdata, 32'h2);
        irq_ack = 1'b1;
        idle(1);
        irq_ack = 1'b0;
        chk("coll_ack_clear", 32'(irq_req), 0);

        // W1C clears a latched bit
        ext_irq = 4'b0001;
        idle(1);
        ext_irq = 4'b0000;
        idle(2);
        chk("w1c_set", 32'(irq_req), 1);
        wr(3'd4, 32'h2);
        chk("w1c_clear", 32'(irq_req), 0);

        // Priority among simultaneous edges
        wr(3'd3, 32'h1E);
        ext_irq = 4'b1010;
        idle(1);
        ext_irq = 4'b0000;
        idle(1);
        chk("prio_latency", 32'(irq_req), 0);
        idle(1);
        chk("prio_req", 32'(irq_req), 1);
        chk("prio_id2", 32'(irq_id), 2);
        irq_ack = 1'b1;
        idle(1);
        irq_ack = 1'b0;
        chk("prio_id4", 32'(irq_id), 4);
        chk("prio_req4", 32'(irq_req), 1);
        irq_ack = 1'b1;
        idle(1);
        irq_ack = 1'b0;
        chk("prio_done", 32'(irq_req), 0);
`else
        // Level: line high sampled at edge n -> request after n+2, immune to ack and W1C
        wr(3'd3, 32'h2);
        ext_irq = 4'b0001;
        idle(1);
        chk("lvl_n0", 32'(irq_req), 0);
        idle(1);
        chk("lvl_n1", 32'(irq_req), 0);
        idle(1);
        chk("lvl_n2", 32'(irq_req), 1);
        chk("lvl_id", 32'(irq_id), 1);
        irq_ack = 1'b1;
        idle(1);
        irq_ack = 1'b0;
        chk("lvl_after_ack", 32'(irq_req), 1);
        wr(3'd4, 32'h2);
        chk("lvl_after_w1c", 32'(irq_req), 1);
        rd(3'd4);
        chk("lvl_pend", rdata, 32'h2);
        ext_irq = 4'b0000;
        idle(1);
        chk("lvl_low_m0", 32'(irq_req), 1);
        idle(1);
        chk("lvl_low_m1", 32'(irq_req), 1);
        idle(1);
        chk("lvl_low_m2", 32'(irq_req), 0);

        // Disabled source stays pending and requests as soon as enabled
        ext_irq = 4'b0100;
        idle(3);
        chk("lvl_dis_req", 32'(irq_req), 0);
        rd(3'd4);
        chk("lvl_dis_pend", rdata, 32'h8);
        wr(3'd3, 32'hA);
        chk("lvl_en_req", 32'(irq_req), 1);
        chk("lvl_en_id", 32'(irq_id), 3);
        ext_irq = 4'b0000;
        idle(3);
        chk("lvl_en_drop", 32'(irq_req), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/intr_timer_ctrl.md
INTR_TIMER_CTRL -- requirements
Module: intr_timer_ctrl

Interface
REQ-001 SHALL have parameter NUM_EXT, default 4, number of external interrupt sources (1..15).
REQ-002 SHALL have parameter TIMER_W, default 32, machine-timer width (8..32).
REQ-003 SHALL have ports: clk  in  1  sole clock, rising edge; rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: ext_irq  in  NUM_EXT  raw external interrupt lines, asynchronous to clk.
REQ-005 SHALL have ports: addr  in  3  register word index; wdata  in  32  write data; wr_en  in  1  write strobe; rd_en  in  1  read strobe; rdata  out  32  read data.
REQ-006 SHALL have ports: irq_req  out  1  interrupt request to CSR unit; irq_id  out  $clog2(NUM_EXT+1)  source id; irq_ack  in  1  one-cycle trap-taken pulse; timer_irq  out  1  raw timer pending.

Function
REQ-007 Source ids SHALL be: 0 = timer, k = ext_irq[k-1].
REQ-008 Register map SHALL be: 0 MTIME rw; 1 MTIMECMP rw; 2 PRESCALE rw (8 bits); 3 ENABLE rw (NUM_EXT+1 bits, bit k = id k); 4 PENDING ro, write-1-to-clear on ext bits; 5-7 read 0, writes ignored.
REQ-009 rdata SHALL be registered, valid the cycle after rd_en, zero-extended; rdata holds when rd_en low.
REQ-010 Prescale counter SHALL count 0..PRESCALE; MTIME increments when counter equals PRESCALE, then counter returns to 0; PRESCALE=0 increments every cycle.
REQ-011 MTIME SHALL wrap from 2^TIMER_W-1 to 0; a write to MTIME SHALL take priority over the increment that cycle.
REQ-012 A write to PRESCALE SHALL clear the prescale counter.
REQ-013 timer_irq SHALL be registered: MTIME >= MTIMECMP (unsigned) sampled each edge; level-type, unaffected by irq_ack or PENDING writes; cleared only by MTIME/MTIMECMP change.
REQ-014 Each ext_irq bit SHALL pass a 2-flop synchroniser before pending logic.
REQ-015 irq_req SHALL equal OR of (PENDING & ENABLE); irq_id SHALL be lowest set index of that vector, 0 when none.
REQ-016 irq_ack SHALL clear the pending bit selected by irq_id (ext sources only) at that edge; irq_req/irq_id re-evaluate next cycle.
REQ-017 Same-cycle set and clear (edge or level vs irq_ack or W1C) of one bit SHALL resolve to set.
REQ-018 irq_ack while irq_req low SHALL have no effect.
REQ-019 Ext latency: level first sampled high at edge n SHALL set pending at edge n+2, irq_req high after it if enabled.
REQ-020 Disabled pending bits SHALL remain pending and SHALL raise irq_req immediately when enabled.

Reset
REQ-021 While rst low: MTIME 0, MTIMECMP all-ones, PRESCALE 0, prescale counter 0, ENABLE 0, PENDING 0, synchronisers 0, rdata 0, timer_irq 0, irq_req 0, irq_id 0.
REQ-022 Reset mid-count or with a request outstanding SHALL discard all state; operation resumes on first edge after rst rises.

Configuration
REQ-023 Macro INTR_EDGE_TRIGGER_EN: defined -> ext pending bit set on synchronised 0->1 transition only, held until irq_ack or W1C; undefined -> ext pending bit follows synchronised level each cycle, irq_ack and W1C have no lasting effect on it.
REQ-024 Timer behaviour SHALL be identical in both configurations.

Verification
REQ-025 Reset: assert rst low mid-count with MTIME=0x55 -> all outputs 0, MTIME reads 0, MTIMECMP reads 0xFFFFFFFF.
REQ-026 Timer: PRESCALE=3, MTIMECMP=10, ENABLE=0x1 -> MTIME steps every 4 cycles; timer_irq and irq_req(id 0) rise one cycle after MTIME reaches 10; write MTIMECMP=100 -> drop next cycle.
REQ-027 Priority (edge build): ENABLE=0x1E, pulse ext_irq[3] and ext_irq[1] together -> irq_id=2; irq_ack -> irq_id=4 next cycle; second irq_ack -> irq_req 0.
REQ-028 Collision (edge build): new edge on ext_irq[0] reaching pending on the irq_ack cycle for id 1 -> PENDING bit 1 stays set, irq_req stays high.
REQ-029 Wrap: TIMER_W=8, write MTIME=0xFF, PRESCALE=0 -> next cycle MTIME=0x00; write MTIME same cycle as increment -> written value read back.
REQ-030 Level build: hold ext_irq[0] high, ENABLE=0x2 -> irq_req high from n+2, stays high through irq_ack; drops 2 cycles after line low.
